// File: rtl/peripheral_collector.sv
// peripheral_collector: first-word-fall-through FIFO that gathers tagged core
// results, stamps each with a sequence number and counts lost strobes.
// Ports:
//   clock, reset (sync, active-low)
//   from_core/from_core_data/from_core_valid : tagged result strobe from the core
//   flush                                    : discard all buffered entries
//   out_tag/out_data/out_seq/out_valid       : head entry, zeroed while empty
//   out_ready                                : host accepts the head entry
//   count/full/empty                         : occupancy after the last edge
//   dropped                                  : saturating count of lost strobes
module peripheral_collector #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int SEQ_BITS   = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [1:0]               from_core,
    input  logic [DATA_WIDTH-1:0]    from_core_data,
    input  logic                     from_core_valid,
    input  logic                     flush,
    output logic [1:0]               out_tag,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic [SEQ_BITS-1:0]      out_seq,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic [15:0]              dropped
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 2 + DATA_WIDTH + SEQ_BITS;

    typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} state_t;

    state_t              state;
    logic [EW-1:0]       mem [DEPTH];
    logic [EW-1:0]       head;
    logic [AW-1:0]       rd_ptr;
    logic [AW-1:0]       wr_ptr;
    logic [SEQ_BITS-1:0] seq;
    logic [CW-1:0]       count_nxt;
    logic                push;
    logic                pop;

    assign empty     = state == EMPTY;
    assign full      = state == FULL;
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready && !flush;
    // a full FIFO still accepts a strobe when the head leaves in the same cycle
    assign push      = from_core_valid && !flush && (!full || pop);
    assign count_nxt = (push && !pop) ? count + CW'(1) :
                       (pop && !push) ? count - CW'(1) : count;

    assign head     = mem[rd_ptr];
    assign out_tag  = out_valid ? head[EW-1 -: 2] : '0;
    assign out_data = out_valid ? head[SEQ_BITS +: DATA_WIDTH] : '0;
    assign out_seq  = out_valid ? head[SEQ_BITS-1:0] : '0;

    always_ff @(posedge clock) begin
        if (reset && push)
            mem[wr_ptr] <= {from_core, from_core_data, seq};
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            seq     <= '0;
            dropped <= '0;
            state   <= EMPTY;
        end else begin
            // the tag advances on every strobe, accepted or not
            if (from_core_valid)
                seq <= seq + SEQ_BITS'(1);
            if (from_core_valid && !push && dropped != 16'hFFFF)
                dropped <= dropped + 16'd1;
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
                state  <= EMPTY;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + AW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
                count <= count_nxt;
                state <= (count_nxt == '0)          ? EMPTY :
                         (count_nxt == CW'(DEPTH)) ? FULL  : PARTIAL;
            end
        end
    end
endmodule

// File: doc/peripheral_collector.md
PERIPHERAL_COLLECTOR -- requirements
Module: peripheral_collector

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH with default 32, the width of each result word.
REQ-002 The block SHALL have parameter DEPTH with default 8, the FIFO entry count (a power of 2, at least 2).
REQ-003 The block SHALL have parameter SEQ_BITS with default 8, the width of the sequence tag.
REQ-004 The block SHALL have a single clock and a synchronous, active-low reset.
REQ-005 The ports SHALL be as follows (name, direction, width, meaning):
- clock  input  1  sole clock; all state updates on its rising edge
- reset  input  1  synchronous, active-low reset
- from_core  input  2  core peripheral tag
- from_core_data  input  DATA_WIDTH  core register result
- from_core_valid  input  1  one-cycle write strobe from the core
- flush  input  1  discard all buffered entries
- out_tag  output  2  head entry tag
- out_data  output  DATA_WIDTH  head entry data
- out_seq  output  SEQ_BITS  head entry sequence number
- out_valid  output  1  head entry present
- out_ready  input  1  host accepts head entry
- count  output  log2(DEPTH)+1  occupied entries
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- dropped  output  16  number of strobes lost to overflow or flush

Function
REQ-006 Each entry SHALL store {tag, data, seq}, where seq is the value of the internal sequence counter at strobe time.
REQ-007 The sequence counter SHALL increment by 1 on every cycle with from_core_valid=1, whether the strobe is accepted or dropped, and SHALL wrap from 2^SEQ_BITS-1 to 0.
REQ-008 A push SHALL occur when from_core_valid=1, flush=0, and either count<DEPTH or a pop occurs in the same cycle.
REQ-009 A pop SHALL occur when out_valid=1, out_ready=1 and flush=0.
REQ-010 A simultaneous push and pop SHALL leave count unchanged; the pushed entry SHALL take the tail slot and the head SHALL advance.
REQ-011 A strobe that is not pushed SHALL increment dropped by 1, saturating at 16'hFFFF.
REQ-012 The block SHALL be first-word-fall-through: an entry pushed into an empty FIFO at edge N SHALL appear on out_* with out_valid=1 after edge N, with no other latency.
REQ-013 While out_valid=1 and out_ready=0, out_tag, out_data and out_seq SHALL hold stable.
REQ-014 Read and write pointers SHALL be log2(DEPTH) bits and SHALL wrap modulo DEPTH.
REQ-015 count, full and empty SHALL reflect the post-edge occupancy; out_valid SHALL equal !empty.
REQ-016 flush=1 SHALL take priority over push and pop; at the next edge, pointers and count SHALL be 0.
REQ-017 On flush, a strobe arriving in the same cycle SHALL be discarded and counted in dropped.
REQ-018 flush SHALL NOT clear dropped or the sequence counter.
REQ-019 The control FSM SHALL have states EMPTY, PARTIAL and FULL, and its transitions SHALL follow count after each edge:
- EMPTY to PARTIAL on push
- PARTIAL to FULL on a push reaching DEPTH
- FULL to PARTIAL on pop without push
- PARTIAL to EMPTY on the last pop
- any state to EMPTY on flush
REQ-020 out_data and out_tag SHALL be 0 when out_valid=0.

Reset
REQ-021 When reset=0 at a rising edge, the block SHALL clear pointers, count, the sequence counter and dropped to 0, and set the FSM to EMPTY.
REQ-022 After reset, the outputs SHALL be: out_valid=0, empty=1, full=0, out_tag=0, out_data=0, out_seq=0.
REQ-023 A reset asserted mid-operation SHALL discard all entries, and a strobe in the same cycle SHALL be ignored and not counted.
REQ-024 Storage array contents SHALL NOT require reset.

Verification
REQ-025 Directed scenario, single pass-through: reset released, strobe tag=0 data=0x2A, out_ready=1 -> next cycle out_valid=1, out_data=0x2A, out_seq=0; one cycle later empty=1.
REQ-026 Directed scenario, fill and overflow: out_ready=0, 10 consecutive strobes data=1..10 -> full=1, count=8, dropped=2; draining yields data 1..8 with seq 0..7.
REQ-027 Directed scenario, push/pop while full: FIFO full, strobe data=0x99 with out_ready=1 -> dropped unchanged, count=8, 0x99 is last out after 7 further pops.
REQ-028 Directed scenario, sequence wrap: 256 accepted strobes with continuous drain -> out_seq runs 255 then 0 on the 257th strobe.
REQ-029 Directed scenario, flush with concurrent strobe: 3 entries buffered, flush=1 together with a strobe -> next cycle empty=1, dropped=+1, and the next accepted entry has out_seq=4.
REQ-030 Directed scenario, reset mid-stream: 5 entries buffered with dropped=3, reset=0 for 1 cycle -> empty=1, dropped=0, and the first later entry has out_seq=0.
